seq_restoring_divider: RTL and testbench

- Multi-cycle unsigned N-bit integer divider for the lab ALU datapath.
- Computes one quotient bit per cycle using restoring division.
- Each iteration sends a trial subtraction through an internal instance of the team's ripple-borrow N-bit subtracter (Nbit_Subtracter), then uses its borrow-out to decide whether to keep the difference or restore the partial remainder.
- Sits beside the ALU as its DIV/MOD functional unit, with a start/busy/done handshake.

---
 rtl/seq_restoring_divider.sv | 197 +++++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle N-bit restoring divider, one quotient bit
// per clock. Each trial subtraction runs through an (N+1)-bit ripple-borrow
// subtracter; its borrow-out selects keep-difference or restore.
// Optional macro DIV_SIGNED_EN: two's-complement operands with truncating
// division (magnitudes divided, signs fixed up while entering DONE).

module Nbit_Subtracter #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         bin_i,
  output logic [W-1:0] diff_o,
  output logic         bout_o
);
  logic [W:0] brw;

  assign brw[0] = bin_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign diff_o[i]  = a_i[i] ^ b_i[i] ^ brw[i];
    assign brw[i + 1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & brw[i]);
  end

  assign bout_o = brw[W];
endmodule

module seq_restoring_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [N:0]      r_q, r_d;       // partial remainder
  logic [N-1:0]    qr_q, qr_d;     // dividend shifting out / quotient shifting in
  logic [N-1:0]    dvs_q, dvs_d;   // captured divisor (magnitude)
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N-1:0]    rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic [N:0]      trial;
  logic [N:0]      diff_w;
  logic            bout_w;
  logic            accept;
  logic            last_iter;
  logic [N-1:0]    dvd_mag, dvs_mag;
  logic            unused_r_msb;

`ifdef DIV_SIGNED_EN
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;

  function automatic logic [N-1:0] neg_if(input logic [N-1:0] v, input logic c);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return c ? (~v + one) : v;
  endfunction

  assign dvd_mag = neg_if(dividend, dividend[N-1]);
  assign dvs_mag = neg_if(divisor, divisor[N-1]);
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  // Bit N of R never feeds the trial value because R stays below the divisor.
  assign unused_r_msb = r_q[N];

  assign trial     = {r_q[N-1:0], qr_q[N-1]};
  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_iter = (cnt_q == CW'(N - 1));

  Nbit_Subtracter #(.W(N + 1)) u_sub (
    .a_i    (trial),
    .b_i    ({1'b0, dvs_q}),
    .bin_i  (1'b0),
    .diff_o (diff_w),
    .bout_o (bout_w)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (divisor == '0) ? DONE : CALC;
        else       state_d = IDLE;
      end
      CALC:    state_d = last_iter ? DONE : CALC;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
  end

  // Datapath next-state: operand capture, one restoring step, result capture
  always_comb begin
    r_d   = r_q;
    qr_d  = qr_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    if (accept) begin
      if (divisor == '0) begin
        quo_d = '1;
        rem_d = dividend;
        dbz_d = 1'b1;
      end else begin
        r_d   = '0;
        qr_d  = dvd_mag;
        dvs_d = dvs_mag;
        cnt_d = '0;
`ifdef DIV_SIGNED_EN
        neg_q_d = dividend[N-1] ^ divisor[N-1];
        neg_r_d = dividend[N-1];
`endif
      end
    end else if (state_q == CALC) begin
      r_d   = bout_w ? trial : diff_w;
      qr_d  = {qr_q[N-2:0], ~bout_w};
      cnt_d = last_iter ? '0 : CW'(cnt_q + 1'b1);
      if (last_iter) begin
`ifdef DIV_SIGNED_EN
        quo_d = neg_if(qr_d, neg_q_q);
        rem_d = neg_if(r_d[N-1:0], neg_r_q);
`else
        quo_d = qr_d;
        rem_d = r_d[N-1:0];
`endif
        dbz_d = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      qr_q  <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      r_q   <= r_d;
      qr_q  <= qr_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (N=8).
module tb_seq_restoring_divider;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;

  seq_restoring_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Present a start for one edge; returns 1 time unit after the accepting edge.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Bounded wait for done; reports cycles waited, busy cycles and busy&done overlaps.
  task automatic wait_done(output int lat, output int busy_n, output int overlap);
    lat = 0;
    busy_n = 0;
    overlap = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (busy && done) overlap++;
  endtask

  task automatic test_reset();
    tests++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic();
    int lat, bn, ov;
    start_op(8'd100, 8'd7);
    wait_done(lat, bn, ov);
    tests++;
    if (lat !== 8 || bn !== 8 || ov !== 0) begin
      fails++;
      $display("FAIL basic_timing: got lat=%0d busy=%0d overlap=%0d, want 8 8 0", lat, bn, ov);
    end
    tests++;
    if (quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, want 14 2 0", quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'd14 || remainder !== 8'd2) begin
      fails++;
      $display("FAIL basic_hold: got done=%b busy=%b q=%0d r=%0d, want 0 0 14 2", done, busy, quotient, remainder);
    end
  endtask

  task automatic test_extremes();
    int lat, bn, ov;
    start_op(8'd255, 8'd1);
    wait_done(lat, bn, ov);
    tests++;
    if (lat !== 8 || quotient !== 8'd255 || remainder !== 8'd0) begin
      fails++;
      $display("FAIL max_by_one: got lat=%0d q=%0d r=%0d, want 8 255 0", lat, quotient, remainder);
    end
    @(posedge clk); #1;
    start_op(8'd0, 8'd9);
    wait_done(lat, bn, ov);
    tests++;
    if (lat !== 8 || quotient !== 8'd0 || remainder !== 8'd0) begin
      fails++;
      $display("FAIL zero_dividend: got lat=%0d q=%0d r=%0d, want 8 0 0", lat, quotient, remainder);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat, bn, ov;
    start_op(8'd5, 8'd0);
    wait_done(lat, bn, ov);
    tests++;
    if (lat !== 0 || bn !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL dbz_timing: got lat=%0d busy_cycles=%0d busy=%b, want 0 0 0", lat, bn, busy);
    end
    tests++;
    if (quotient !== 8'hFF || remainder !== 8'd5 || div_by_zero !== 1'b1) begin
      fails++;
      $display("FAIL dbz_result: got q=%h r=%0d dbz=%b, want ff 5 1", quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || div_by_zero !== 1'b1) begin
      fails++;
      $display("FAIL dbz_pulse: got done=%b dbz=%b, want 0 1", done, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bn, ov;
    logic [N-1:0] eq, er;
`ifdef DIV_SIGNED_EN
    eq = 8'hEE; er = 8'hFE;   // -56 / 3 = -18 rem -2
`else
    eq = 8'd66; er = 8'd2;
`endif
    start_op(8'd200, 8'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_op(8'd10, 8'd2);    // lands on edge 3: must be ignored
    wait_done(lat, bn, ov);
    tests++;
    if (lat !== 5 || ov !== 0) begin
      fails++;
      $display("FAIL ignore_start_timing: got lat_after_edge3=%0d overlap=%0d, want 5 0", lat, ov);
    end
    tests++;
    if (quotient !== eq || remainder !== er) begin
      fails++;
      $display("FAIL ignore_start_result: got q=%h r=%h, want %h %h", quotient, remainder, eq, er);
    end
    start_op(8'd10, 8'd2);    // issued during DONE
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(lat, bn, ov);
    tests++;
    if (lat !== 8 || quotient !== 8'd5 || remainder !== 8'd0) begin
      fails++;
      $display("FAIL b2b_result: got lat=%0d q=%0d r=%0d, want 8 5 0", lat, quotient, remainder);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int lat, bn, ov;
    start_op(8'd100, 8'd7);
    wait_done(lat, bn, ov);
    @(posedge clk); #1;
    start_op(8'd77, 8'd5);
    repeat (4) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      fails++;
      $display("FAIL async_reset: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
    start_op(8'd77, 8'd5);
    wait_done(lat, bn, ov);
    tests++;
    if (lat !== 8 || quotient !== 8'd15 || remainder !== 8'd2) begin
      fails++;
      $display("FAIL after_reset: got lat=%0d q=%0d r=%0d, want 8 15 2", lat, quotient, remainder);
    end
    @(posedge clk); #1;
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    int lat, bn, ov;
    start_op(8'hF9, 8'd2);
    wait_done(lat, bn, ov);
    tests++;
    if (lat !== 8 || quotient !== 8'hFD || remainder !== 8'hFF) begin
      fails++;
      $display("FAIL signed_neg_dvd: got lat=%0d q=%h r=%h, want 8 fd ff", lat, quotient, remainder);
    end
    @(posedge clk); #1;
    start_op(8'd7, 8'hFE);
    wait_done(lat, bn, ov);
    tests++;
    if (quotient !== 8'hFD || remainder !== 8'h01) begin
      fails++;
      $display("FAIL signed_neg_dvs: got q=%h r=%h, want fd 01", quotient, remainder);
    end
    @(posedge clk); #1;
    start_op(8'h80, 8'hFF);
    wait_done(lat, bn, ov);
    tests++;
    if (quotient !== 8'h80 || remainder !== 8'h00) begin
      fails++;
      $display("FAIL signed_min_by_m1: got q=%h r=%h, want 80 00", quotient, remainder);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_extremes();
    test_div_zero();
    test_back_to_back();
    test_async_reset();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
